// File: rtl/alu_sched_pkg.sv
// Shared definitions for the ALU issue scheduler: ALU control codes, FSM state
// encoding and the known-opcode helper.
package alu_sched_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0011;
  localparam logic [3:0] ALU_MUL = 4'b0100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_MUL  = 2'b10,
    ST_RESP = 2'b11
  } state_t;

  function automatic logic is_known_op(input logic [3:0] code);
    logic known;
    case (code)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_MUL: known = 1'b1;
      default:                                    known = 1'b0;
    endcase
    return known;
  endfunction

endpackage

// File: rtl/alu_issue_sched_if.sv
// Request, ALU-side and response bundle of the ALU issue scheduler.
// slave = scheduler view, master = surrounding requesters/ALU/consumer.
interface alu_issue_sched_if #(parameter int W = 32);

  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [3:0]   req0_ctrl;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic [3:0]   req1_ctrl;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic [3:0]   alu_ctrl;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [W-1:0] alu_result;
  logic         alu_zero;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [W-1:0] rsp_result;
  logic         rsp_zero;

  modport slave (
    input  req_valid, req0_ctrl, req0_a, req0_b, req1_ctrl, req1_a, req1_b,
    input  alu_result, alu_zero, rsp_ready,
    output req_ready, alu_ctrl, alu_a, alu_b, rsp_valid, rsp_id, rsp_result, rsp_zero
  );

  modport master (
    output req_valid, req0_ctrl, req0_a, req0_b, req1_ctrl, req1_a, req1_b,
    output alu_result, alu_zero, rsp_ready,
    input  req_ready, alu_ctrl, alu_a, alu_b, rsp_valid, rsp_id, rsp_result, rsp_zero
  );

endinterface

// File: rtl/alu_rr_arb2.sv
// Two-way grant logic. ALU_SCHED_RR_EN selects round-robin on contention;
// otherwise requester 0 has fixed priority and last_grant is ignored.
module alu_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

`ifdef ALU_SCHED_RR_EN
  // Contention goes to the requester that did not win the previous handshake.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end
`else
  logic unused_last_grant_s;
  assign unused_last_grant_s = last_grant;

  // Requester 0 always wins contention.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = 2'b01;
      default: grant = 2'b00;
    endcase
  end
`endif

endmodule

// File: rtl/alu_issue_sched.sv
// Issues one operation at a time from two requesters onto the shared ALU and
// returns the captured result with a requester tag. Macro: ALU_SCHED_RR_EN.
module alu_issue_sched
  import alu_sched_pkg::*;
#(
  parameter int W          = 32,
  parameter int MUL_CYCLES = 3
) (
  input  logic              clk,
  input  logic              reset,
  alu_issue_sched_if.slave  bus,
  output logic              busy
);

  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t        state_r, next_state_s;
  logic [3:0]    ctrl_r;
  logic [W-1:0]  a_r, b_r, res_r;
  logic          tag_r, zero_r, last_s;
  logic [CW-1:0] cnt_r;
  logic [1:0]    grant_s, ready_s;
  logic          accept_s, accept_id_s, capture_s;
  logic [3:0]    sel_ctrl_s;
  logic [W-1:0]  sel_a_s, sel_b_s;

  alu_rr_arb2 u_arb (
    .req        (bus.req_valid),
    .last_grant (last_s),
    .grant      (grant_s)
  );

  // Grants are only offered while idle.
  always_comb begin
    ready_s = 2'b00;
    if (state_r == ST_IDLE) ready_s = grant_s;
    else                    ready_s = 2'b00;
  end

  assign accept_s    = |(bus.req_valid & ready_s);
  assign accept_id_s = ready_s[1];

  // Payload of the granted requester.
  always_comb begin
    sel_ctrl_s = bus.req0_ctrl;
    sel_a_s    = bus.req0_a;
    sel_b_s    = bus.req0_b;
    if (accept_id_s) begin
      sel_ctrl_s = bus.req1_ctrl;
      sel_a_s    = bus.req1_a;
      sel_b_s    = bus.req1_b;
    end else begin
      sel_ctrl_s = bus.req0_ctrl;
      sel_a_s    = bus.req0_a;
      sel_b_s    = bus.req0_b;
    end
  end

  // Next-state and capture strobe.
  always_comb begin
    next_state_s = state_r;
    capture_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) next_state_s = (sel_ctrl_s == ALU_MUL) ? ST_MUL : ST_EXEC;
        else          next_state_s = ST_IDLE;
      end
      ST_EXEC: begin
        capture_s    = 1'b1;
        next_state_s = ST_RESP;
      end
      ST_MUL: begin
        if (cnt_r == CNT_ZERO) begin
          capture_s    = 1'b1;
          next_state_s = ST_RESP;
        end else begin
          next_state_s = ST_MUL;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) next_state_s = ST_IDLE;
        else               next_state_s = ST_RESP;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= next_state_s;
  end

  // Operand, counter and response registers; unknown codes respond 0 / zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_r <= 4'b0000;
      a_r    <= '0;
      b_r    <= '0;
      tag_r  <= 1'b0;
      cnt_r  <= CNT_ZERO;
      res_r  <= '0;
      zero_r <= 1'b0;
    end else begin
      if (accept_s) begin
        ctrl_r <= sel_ctrl_s;
        a_r    <= sel_a_s;
        b_r    <= sel_b_s;
        tag_r  <= accept_id_s;
        cnt_r  <= CNT_LOAD;
      end else if ((state_r == ST_MUL) && (cnt_r != CNT_ZERO)) begin
        cnt_r  <= cnt_r - CNT_ONE;
      end
      if (capture_s) begin
        res_r  <= is_known_op(ctrl_r) ? bus.alu_result : '0;
        zero_r <= is_known_op(ctrl_r) ? bus.alu_zero : 1'b1;
      end
    end
  end

`ifdef ALU_SCHED_RR_EN
  logic last_r;
  // Last-grant pointer; moves only on a completed handshake.
  always_ff @(posedge clk) begin
    if (reset)         last_r <= 1'b1;
    else if (accept_s) last_r <= accept_id_s;
    else               last_r <= last_r;
  end
  assign last_s = last_r;
`else
  assign last_s = 1'b1;
`endif

  assign bus.req_ready  = ready_s;
  assign bus.alu_ctrl   = ctrl_r;
  assign bus.alu_a      = a_r;
  assign bus.alu_b      = b_r;
  assign bus.rsp_valid  = (state_r == ST_RESP);
  assign bus.rsp_id     = tag_r;
  assign bus.rsp_result = res_r;
  assign bus.rsp_zero   = zero_r;
  assign busy           = (state_r != ST_IDLE);

endmodule

// File: tb/tb_alu_issue_sched.sv
// Self-checking bench for alu_issue_sched: directed cases plus randomized traffic
// compared each cycle against a transaction-level model.
module tb_alu_issue_sched;

  localparam int W  = 32;
  localparam int MC = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy;

  always #5 clk = ~clk;

  alu_issue_sched_if #(.W(W)) bus ();

  alu_issue_sched #(.W(W), .MUL_CYCLES(MC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic known(input logic [3:0] c);
    return (c <= 4'd4);
  endfunction

  // Combinational ALU stand-in; unknown codes give a nonzero, non-zero-flag value.
  function automatic logic [31:0] alu_fn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd3:    return a - b;
      4'd4:    return a * b;
      default: return (a ^ b) | 32'h0000_0100;
    endcase
  endfunction

  assign bus.alu_result = alu_fn(bus.alu_ctrl, bus.alu_a, bus.alu_b);
  assign bus.alu_zero   = known(bus.alu_ctrl) && (bus.alu_result == 32'd0);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model / compare process ----------------
  int          cyc = 0;
  logic        m_active = 1'b0;
  int          m_rsp_cyc = 0;
  logic        m_id = 1'b0;
  logic [31:0] m_res = 32'd0;
  logic        m_zero = 1'b0;
  logic        m_ptr = 1'b1;
  logic [3:0]  l_ctrl = 4'd0;
  logic [31:0] l_a = 32'd0;
  logic [31:0] l_b = 32'd0;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        m_active = 1'b0;
        m_ptr    = 1'b1;
        l_ctrl   = 4'd0;
        l_a      = 32'd0;
        l_b      = 32'd0;
      end else begin
        int g;
        logic [3:0]  c;
        logic [31:0] a, b;
        cyc++;
        check("alu_ctrl", bus.alu_ctrl, l_ctrl);
        check("alu_a", bus.alu_a, l_a);
        check("alu_b", bus.alu_b, l_b);
        if (m_active) begin
          check("req_ready_busy", bus.req_ready, 2'b00);
          check("busy_active", busy, 1'b1);
          if (cyc >= m_rsp_cyc) begin
            check("rsp_valid", bus.rsp_valid, 1'b1);
            check("rsp_id", bus.rsp_id, m_id);
            check("rsp_result", bus.rsp_result, m_res);
            check("rsp_zero", bus.rsp_zero, m_zero);
            if (bus.rsp_ready) m_active = 1'b0;
          end else begin
            check("rsp_valid_early", bus.rsp_valid, 1'b0);
          end
        end else begin
          check("busy_idle", busy, 1'b0);
          check("rsp_valid_idle", bus.rsp_valid, 1'b0);
          g = -1;
          if (bus.req_valid == 2'b11) begin
`ifdef ALU_SCHED_RR_EN
            g = m_ptr ? 0 : 1;
`else
            g = 0;
`endif
          end else if (bus.req_valid[0]) g = 0;
          else if (bus.req_valid[1]) g = 1;
          check("req_ready", bus.req_ready, (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00);
          if (g >= 0) begin
            c = (g == 1) ? bus.req1_ctrl : bus.req0_ctrl;
            a = (g == 1) ? bus.req1_a : bus.req0_a;
            b = (g == 1) ? bus.req1_b : bus.req0_b;
            m_active  = 1'b1;
            m_id      = (g == 1);
            m_rsp_cyc = cyc + ((c == 4'd4) ? (1 + MC) : 2);
            m_res     = known(c) ? alu_fn(c, a, b) : 32'd0;
            m_zero    = known(c) ? (m_res == 32'd0) : 1'b1;
            m_ptr     = (g == 1);
            l_ctrl    = c;
            l_a       = a;
            l_b       = b;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic        pend [2];
  logic [3:0]  pc [2];
  logic [31:0] pa [2];
  logic [31:0] pb [2];

  task automatic drive_reqs();
    bus.req_valid = {pend[1], pend[0]};
    bus.req0_ctrl = pc[0]; bus.req0_a = pa[0]; bus.req0_b = pb[0];
    bus.req1_ctrl = pc[1]; bus.req1_a = pa[1]; bus.req1_b = pb[1];
  endtask

  task automatic new_payload(input int r);
    int x;
    x = int'($urandom_range(9));
    if (x <= 4)      pc[r] = 4'(x);
    else if (x <= 6) pc[r] = 4'd4;
    else             pc[r] = 4'($urandom_range(15));
    pa[r] = ($urandom_range(3) == 0) ? 32'($urandom_range(3)) : $urandom();
    pb[r] = ($urandom_range(3) == 0) ? 32'($urandom_range(3)) : $urandom();
  endtask

  // Directed single op: wait for accept, check latency and captured values, optionally stall.
  task automatic issue(input int r, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic ez, input int elat, input int hold);
    bit got;
    int k;
    @(posedge clk); #1;
    pend[0] = (r == 0); pend[1] = (r == 1);
    pc[r] = c; pa[r] = a; pb[r] = b;
    drive_reqs();
    bus.rsp_ready = (hold == 0);
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (bus.req_ready[r]) got = 1'b1;
    end
    check("accept", got, 1'b1);
    @(posedge clk); #1;
    pend[0] = 1'b0; pend[1] = 1'b0;
    drive_reqs();
    got = 1'b0;
    k = 0;
    while (!got && k < 40) begin
      @(negedge clk);
      k++;
      if (k == 1) check("alu_ctrl_T1", bus.alu_ctrl, c);
      if (bus.rsp_valid) got = 1'b1;
    end
    check("latency", k, elat);
    check("d_result", bus.rsp_result, er);
    check("d_zero", bus.rsp_zero, ez);
    check("d_id", bus.rsp_id, r[0]);
    if (hold > 0) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        check("hold_valid", bus.rsp_valid, 1'b1);
        check("hold_result", bus.rsp_result, er);
        check("hold_zero", bus.rsp_zero, ez);
      end
      @(posedge clk); #1;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
    end
  endtask

  int cnt_g [2];

  task automatic rand_phase(input int n, input int pvalid, input int prdy, input bit count);
    logic [1:0] hs;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      hs = bus.req_valid & bus.req_ready;
      if (count && hs[0]) cnt_g[0]++;
      if (count && hs[1]) cnt_g[1]++;
      @(posedge clk); #1;
      for (int r = 0; r < 2; r++) begin
        if (hs[r]) pend[r] = 1'b0;
        if (!pend[r]) begin
          new_payload(r);
          if (int'($urandom_range(99)) < pvalid) pend[r] = 1'b1;
        end
      end
      drive_reqs();
      bus.rsp_ready = (int'($urandom_range(99)) < prdy);
    end
  endtask

  initial begin
    pend[0] = 1'b0; pend[1] = 1'b0;
    pc[0] = 4'd0; pc[1] = 4'd0; pa[0] = 32'd0; pa[1] = 32'd0; pb[0] = 32'd0; pb[1] = 32'd0;
    cnt_g[0] = 0; cnt_g[1] = 0;
    drive_reqs();
    bus.rsp_ready = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_req_ready", bus.req_ready, 2'b00);
    check("rst_alu_ctrl", bus.alu_ctrl, 4'b0000);
    check("rst_alu_a", bus.alu_a, 32'd0);
    check("rst_rsp_result", bus.rsp_result, 32'd0);
    check("rst_rsp_id", bus.rsp_id, 1'b0);
    check("rst_rsp_zero", bus.rsp_zero, 1'b0);

    issue(0, 4'b0010, 32'd5, 32'd7, 32'd12, 1'b0, 2, 0);
    issue(1, 4'b0100, 32'd6, 32'd7, 32'd42, 1'b0, 1 + MC, 0);
    issue(0, 4'b0011, 32'd9, 32'd9, 32'd0, 1'b1, 2, 5);
    issue(0, 4'b1111, 32'd3, 32'd5, 32'd0, 1'b1, 2, 0);
    issue(1, 4'b0001, 32'hF0, 32'h0F, 32'hFF, 1'b0, 2, 0);

    // Reset while a MUL is in flight: the op must vanish without a response.
    @(posedge clk); #1;
    pend[0] = 1'b1; pc[0] = 4'b0100; pa[0] = 32'd3; pb[0] = 32'd4;
    drive_reqs();
    @(negedge clk);
    check("mul_accept", bus.req_ready, 2'b01);
    @(posedge clk); #1;
    pend[0] = 1'b0;
    drive_reqs();
    @(negedge clk);
    check("mul_busy", busy, 1'b1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_valid", bus.rsp_valid, 1'b0);
      check("post_rst_busy", busy, 1'b0);
    end

    rand_phase(1500, 40, 70, 1'b0);
    cnt_g[0] = 0; cnt_g[1] = 0;
    rand_phase(200, 100, 100, 1'b1);
`ifdef ALU_SCHED_RR_EN
    check("rr_alternate", ((cnt_g[0] - cnt_g[1]) <= 1) && ((cnt_g[1] - cnt_g[0]) <= 1) && (cnt_g[1] > 0), 1'b1);
`else
    check("fixed_prio_req1", cnt_g[1], 0);
    check("fixed_prio_req0", cnt_g[0] > 0, 1'b1);
`endif
    rand_phase(1500, 50, 60, 1'b0);
    rand_phase(60, 0, 100, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
